// File: rtl/wb_uart_defs.sv
// Shared definitions for the Wishbone UART transmitter: register map, STATUS bit
// positions and serializer state encoding.
package wb_uart_defs;

    // Register selects are word indices taken from wb_adr_i[3:2] (byte offsets 0x0/0x4/0x8).
    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVISOR = 2'd2;

    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_BUSY      = 2;
    localparam int ST_OVF       = 3;
    localparam int ST_IRQ_EN    = 4;
    localparam int ST_LEVEL_LSB = 8;

    localparam int BITCNT_W = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } ser_state_t;

    function automatic logic [15:0] div_reset(input int clk_hz, input int baud);
        return 16'(clk_hz / baud);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with extra-MSB pointers; pushes while full and pops while
// empty are ignored.
module uart_tx_fifo #(
    parameter int AW = 4
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          i_push,
    input  logic [7:0]    i_data,
    input  logic          i_pop,
    output logic [7:0]    o_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_level
);

    logic [7:0]  r_mem [2**AW];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_do_push;
    logic        w_do_pop;

    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_level   = r_wr_ptr - r_rd_ptr;
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/wb_uart_tx.sv
// Wishbone classic slave UART transmitter: register file, TX FIFO and an 8N1
// serializer running at a programmable clocks-per-bit divisor.
module wb_uart_tx
    import wb_uart_defs::*;
#(
    parameter int CLK_FREQ_HZ = 24000000,
    parameter int BAUD        = 115200,
    parameter int FIFO_AW     = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [3:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    output logic        uart_tx,
    output logic        irq_o,
    output logic [4:0]  o_dbg_state
);

    localparam logic [FIFO_AW:0] LP_HALF = (FIFO_AW+1)'(2 ** (FIFO_AW - 1));

    logic               r_ack;
    logic [31:0]        r_dat;
    logic [15:0]        r_div;
    logic               r_ovf;
    logic               r_irq_en;

    ser_state_t         r_state;
    ser_state_t         w_state_nx;
    logic [BITCNT_W-1:0] r_bitcnt;
    logic [BITCNT_W-1:0] w_bitcnt_nx;
    logic [15:0]        r_cnt;
    logic [15:0]        w_cnt_nx;
    logic [7:0]         r_shift;
    logic [7:0]         w_shift_nx;
    logic [15:0]        r_div_lat;
    logic [15:0]        w_div_lat_nx;
    logic               r_tx;
    logic               w_tx_nx;
    logic               w_load;

    logic               w_req;
    logic               w_wr;
    logic [1:0]         w_reg;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [FIFO_AW:0]   w_level;
    logic [7:0]         w_fifo_data;
    logic [15:0]        w_div_eff;
    logic [31:0]        w_status;
    logic [31:0]        w_rdata;
    logic               w_unused;

    // A new request is accepted only when ack is low, so accesses take two clocks;
    // register side effects fire in the ack cycle while the master still holds the bus.
    assign w_req     = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_wr      = r_ack & wb_cyc_i & wb_stb_i & wb_we_i;
    assign w_reg     = wb_adr_i[3:2];
    assign w_push    = w_wr && (w_reg == REG_TXDATA) && wb_sel_i[0];
    assign w_div_eff = (r_div == 16'd0) ? 16'd1 : r_div;
    assign w_unused  = &{1'b0, wb_adr_i[1:0], wb_sel_i[3:2], wb_dat_i[31:16]};

    assign wb_ack_o    = r_ack;
    assign wb_dat_o    = r_dat;
    assign uart_tx     = r_tx;
    assign irq_o       = r_irq_en && (w_level < LP_HALF);
    assign o_dbg_state = {r_state, r_bitcnt};

    uart_tx_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_data  (wb_dat_i[7:0]),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    always_comb begin
        w_status                                    = '0;
        w_status[ST_FULL]                           = w_full;
        w_status[ST_EMPTY]                          = w_empty;
        w_status[ST_BUSY]                           = ~w_empty | (r_state != S_IDLE);
        w_status[ST_OVF]                            = r_ovf;
        w_status[ST_IRQ_EN]                         = r_irq_en;
        w_status[FIFO_AW+ST_LEVEL_LSB:ST_LEVEL_LSB] = w_level;
    end

    always_comb begin
        case (w_reg)
            REG_STATUS:  w_rdata = w_status;
            REG_DIVISOR: w_rdata = {16'h0000, r_div};
            default:     w_rdata = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ack    <= 1'b0;
            r_dat    <= '0;
            r_div    <= div_reset(CLK_FREQ_HZ, BAUD);
            r_ovf    <= 1'b0;
            r_irq_en <= 1'b0;
        end else begin
            r_ack <= w_req;
            r_dat <= (w_req && !wb_we_i) ? w_rdata : '0;
            if (w_push && w_full) begin
                r_ovf <= 1'b1;
            end
            if (w_wr && (w_reg == REG_STATUS)) begin
                if (wb_dat_i[ST_OVF]) r_ovf <= 1'b0;
                r_irq_en <= wb_dat_i[ST_IRQ_EN];
            end
            if (w_wr && (w_reg == REG_DIVISOR)) begin
                if (wb_sel_i[0]) r_div[7:0]  <= wb_dat_i[7:0];
                if (wb_sel_i[1]) r_div[15:8] <= wb_dat_i[15:8];
            end
        end
    end

    // Serializer: every state lasts r_div_lat clocks; STOP chains straight into START
    // when another byte is waiting so back-to-back frames have no idle gap.
    always_comb begin
        w_state_nx   = r_state;
        w_bitcnt_nx  = r_bitcnt;
        w_cnt_nx     = r_cnt;
        w_shift_nx   = r_shift;
        w_div_lat_nx = r_div_lat;
        w_tx_nx      = r_tx;
        w_load       = 1'b0;
        w_pop        = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_tx_nx = 1'b1;
                w_load  = ~w_empty;
            end
            S_START: begin
                if (r_cnt == 16'd0) begin
                    w_state_nx  = S_DATA;
                    w_bitcnt_nx = '0;
                    w_cnt_nx    = r_div_lat - 16'd1;
                    w_tx_nx     = r_shift[0];
                end else begin
                    w_cnt_nx = r_cnt - 16'd1;
                end
            end
            S_DATA: begin
                if (r_cnt == 16'd0) begin
                    w_cnt_nx = r_div_lat - 16'd1;
                    if (r_bitcnt == 3'd7) begin
                        w_state_nx = S_STOP;
                        w_tx_nx    = 1'b1;
                    end else begin
                        w_bitcnt_nx = r_bitcnt + 3'd1;
                        w_shift_nx  = {1'b0, r_shift[7:1]};
                        w_tx_nx     = r_shift[1];
                    end
                end else begin
                    w_cnt_nx = r_cnt - 16'd1;
                end
            end
            S_STOP: begin
                if (r_cnt == 16'd0) begin
                    w_load     = ~w_empty;
                    w_state_nx = S_IDLE;
                    w_tx_nx    = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt - 16'd1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_tx_nx    = 1'b1;
            end
        endcase

        if (w_load) begin
            w_pop        = 1'b1;
            w_state_nx   = S_START;
            w_bitcnt_nx  = '0;
            w_shift_nx   = w_fifo_data;
            w_div_lat_nx = w_div_eff;
            w_cnt_nx     = w_div_eff - 16'd1;
            w_tx_nx      = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_bitcnt  <= '0;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_div_lat <= 16'd1;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_nx;
            r_bitcnt  <= w_bitcnt_nx;
            r_cnt     <= w_cnt_nx;
            r_shift   <= w_shift_nx;
            r_div_lat <= w_div_lat_nx;
            r_tx      <= w_tx_nx;
        end
    end

endmodule

// File: tb/tb_wb_uart_tx.sv
// Directed bench for wb_uart_tx: bus accesses from one initial block, a line
// monitor decoding 8N1 frames against a queue of expected bytes and divisors.
module tb_wb_uart_tx;

  // Bus handshake: a request is cyc&stb held until ack is seen, then held through
  // the ack cycle and dropped after the following clock edge.

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic [3:0]  wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_we_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_ack_o;
  logic        uart_tx;
  logic        irq_o;
  logic [4:0]  dbg_state;

  int          cyc_cnt = 0;
  int          n_total = 0;
  int          n_pass = 0;
  int          rx_done = 0;
  logic [7:0]  exp_q[$];
  int          div_q[$];
  int          start_q[$];

  wb_uart_tx dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .wb_adr_i    (wb_adr_i),
    .wb_dat_i    (wb_dat_i),
    .wb_dat_o    (wb_dat_o),
    .wb_sel_i    (wb_sel_i),
    .wb_we_i     (wb_we_i),
    .wb_cyc_i    (wb_cyc_i),
    .wb_stb_i    (wb_stb_i),
    .wb_ack_o    (wb_ack_o),
    .uart_tx     (uart_tx),
    .irq_o       (irq_o),
    .o_dbg_state (dbg_state)
  );

  // clock / cycle counter
  always #5 clock = ~clock;
  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic wb_cycle(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic we, output logic [31:0] rd, output int ack_at);
    int n;
    @(posedge clock); #1;
    wb_adr_i = a; wb_dat_i = d; wb_sel_i = s; wb_we_i = we;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    n = 0;
    do begin
      @(posedge clock); #1; n++;
    end while (wb_ack_o !== 1'b1 && n < 16);
    chk("ack_seen", 32'(wb_ack_o), 32'd1);
    rd = wb_dat_o;
    ack_at = cyc_cnt;
    @(posedge clock); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_sel_i = '0;
  endtask

  task automatic wb_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd;
    int at;
    wb_cycle(a, d, s, 1'b1, rd, at);
  endtask

  task automatic wb_read_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    int at;
    wb_cycle(a, 32'h0, 4'hF, 1'b0, rd, at);
    chk(tag, rd, exp);
  endtask

  task automatic push(input logic [7:0] b, input int d, output int ack_at);
    logic [31:0] rd;
    exp_q.push_back(b);
    div_q.push_back(d);
    wb_cycle(4'h0, {24'h0, b}, 4'h1, 1'b1, rd, ack_at);
  endtask

  task automatic wait_rx(input int target, input int bound);
    int n = 0;
    while (rx_done < target && n < bound) begin
      @(posedge clock); n++;
    end
    chk("rx_frames_done", 32'(rx_done), 32'(target));
  endtask

  task automatic wait_start(input int target, input int bound);
    int n = 0;
    while (start_q.size() < target && n < bound) begin
      @(posedge clock); n++;
    end
    chk("start_seen", 32'(start_q.size()), 32'(target));
    #1;
  endtask

  // scoreboard: decode each frame at bit centres and compare with the expected queue
  initial begin
    logic [7:0] b;
    logic       st;
    logic       sp;
    logic       abort;
    logic [7:0] e;
    int         d;
    forever begin
      @(negedge clock);
      if (reset_n === 1'b1 && uart_tx === 1'b0) begin
        start_q.push_back(cyc_cnt);
        chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          d = div_q.pop_front();
          abort = 1'b0;
          for (int k = 0; k < d / 2; k++) begin
            @(negedge clock); if (!reset_n) abort = 1'b1;
          end
          st = uart_tx;
          for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < d; k++) begin
              @(negedge clock); if (!reset_n) abort = 1'b1;
            end
            b[i] = uart_tx;
          end
          for (int k = 0; k < d; k++) begin
            @(negedge clock); if (!reset_n) abort = 1'b1;
          end
          sp = uart_tx;
          if (!abort) begin
            chk("rx_frame", {22'h0, sp, b, st}, {22'h0, 1'b1, e, 1'b0});
            rx_done++;
          end
        end else begin
          repeat (16) @(negedge clock);
        end
      end
    end
  end

  initial begin
    int a0;
    int s0;
    int n;

    // 1: reset
    #1 reset_n = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    chk("reset_uart_tx", 32'(uart_tx), 32'd1);
    chk("reset_ack", 32'(wb_ack_o), 32'd0);
    chk("reset_dat_o", wb_dat_o, 32'd0);
    chk("reset_irq", 32'(irq_o), 32'd0);
    chk("reset_fsm", 32'(dbg_state), 32'd0);
    reset_n = 1'b1;
    wb_read_chk("reset_status", 4'h4, 32'h0000_0002);
    wb_read_chk("reset_divisor", 4'h8, 32'd208);
    wb_read_chk("reserved_read", 4'hC, 32'h0);
    wb_write(4'hC, 32'hFFFF_FFFF, 4'hF);
    wb_write(4'h8, 32'h0000_1234, 4'h1);
    wb_read_chk("divisor_lane0_only", 4'h8, 32'h0000_0034);
    wb_write(4'h0, 32'h99, 4'h2);
    wb_read_chk("txdata_sel0_low_ignored", 4'h4, 32'h0000_0002);

    // 2: single byte, DIVISOR=4
    wb_write(4'h8, 32'd4, 4'h3);
    wb_read_chk("divisor_4", 4'h8, 32'd4);
    start_q.delete();
    push(8'h55, 4, a0);
    wait_start(1, 50);
    chk("start_latency", 32'(start_q[0] - a0), 32'd2);
    wb_read_chk("status_busy", 4'h4, 32'h0000_0006);
    wait_rx(1, 100);
    repeat (8) @(posedge clock);
    wb_read_chk("status_idle_after_frame", 4'h4, 32'h0000_0002);

    // 3: back-to-back frames
    start_q.delete();
    push(8'hA5, 4, a0);
    push(8'h3C, 4, a0);
    wait_start(2, 100);
    chk("back_to_back_spacing", 32'(start_q[1] - start_q[0]), 32'd40);
    wait_rx(3, 100);

    // 4: overflow (DIVISOR=100 keeps the FIFO full while pushing)
    wb_write(4'h8, 32'd100, 4'h3);
    for (int i = 0; i < 17; i++) push(8'(8'h10 + i), 100, a0);
    wb_read_chk("status_full", 4'h4, 32'h0000_1005);
    wb_write(4'h0, 32'hEE, 4'h1);
    wb_read_chk("status_ovf", 4'h4, 32'h0000_100D);
    wb_write(4'h4, 32'h18, 4'hF);
    wb_read_chk("status_ovf_cleared_irq_en", 4'h4, 32'h0000_1015);
    chk("irq_low_when_full", 32'(irq_o), 32'd0);
    wait_rx(20, 18000);
    repeat (120) @(posedge clock);
    #1;
    chk("irq_high_when_drained", 32'(irq_o), 32'd1);
    wb_read_chk("status_drained", 4'h4, 32'h0000_0012);
    wb_write(4'h4, 32'h0, 4'hF);
    #1;
    chk("irq_disabled", 32'(irq_o), 32'd0);

    // 5: divisor change mid-frame
    wb_write(4'h8, 32'd8, 4'h3);
    start_q.delete();
    push(8'h81, 8, a0);
    wait_start(1, 50);
    repeat (20) @(posedge clock);
    wb_write(4'h8, 32'd16, 4'h3);
    push(8'h7E, 16, a0);
    wait_start(2, 200);
    chk("frame1_div8_length", 32'(start_q[1] - start_q[0]), 32'd80);
    wait_rx(22, 400);

    // 6: async reset during DATA bit 3
    wb_write(4'h8, 32'd8, 4'h3);
    start_q.delete();
    push(8'hF0, 8, a0);
    wait_start(1, 50);
    s0 = start_q[0];
    n = 0;
    while (cyc_cnt < s0 + 35 && n < 200) begin
      @(posedge clock); #1; n++;
    end
    chk("tx_low_before_reset", 32'(uart_tx), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("tx_high_on_reset", 32'(uart_tx), 32'd1);
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    exp_q.delete();
    div_q.delete();
    chk("fsm_idle_after_reset", 32'(dbg_state), 32'd0);
    wb_read_chk("status_after_reset", 4'h4, 32'h0000_0002);
    wb_read_chk("divisor_after_reset", 4'h8, 32'd208);
    repeat (20) @(posedge clock);
    #1;
    chk("line_idle_after_reset", 32'(uart_tx), 32'd1);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
